pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined, flow-controlled adder/subtractor. It is the next generation of the team's ripple-carry full-adder chain.
- The WIDTH-bit operation is split into STAGES equal chunks. One chunk is resolved per pipeline stage, and the carry is registered between stages, so clock rate is independent of WIDTH.
- Carries carry-in/borrow-in, add/sub mode, carry-out, signed overflow and zero flags.
- Valid/ready on both sides. Sits between operand sources and the register-file write-back path of the RISC datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH). Chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept a beat this cycle
- augend  input  WIDTH  operand A
- addend  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- op  input  1  0 = add, 1 = subtract
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result this cycle
- sum  output  WIDTH  result
- cout  output  1  raw carry out of MSB (for sub: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  sum == 0

Behaviour:
- Reset:
  - Asserting reset clears all stage valid bits and data registers immediately, including in mid-operation.
  - While reset is high, out_valid, sum, cout, ovf and zero are all 0.
  - In-flight beats are discarded.
  - in_ready is 1 from the first edge after reset deasserts.
- Arithmetic:
  - Effective B = op ? ~addend : addend.
  - Effective carry-in = op ? ~cin : cin.
  - Add: sum = A + B + cin. Sub: sum = A - B - cin.
  - Results are mod 2^WIDTH.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (sum == 0).
  - cout is the raw carry and is not inverted for sub.
- Pipeline:
  - Stage k (1..STAGES) holds: a valid bit, the completed low k*CW result bits, the carry out of chunk k-1, the remaining unprocessed operand chunks (B already conditioned), and op.
  - Stage 1 computes chunk 0 from the inputs combinationally and registers it on accept.
  - Stage k adds chunk k-1 plus the registered carry.
  - The final stage register drives sum/cout/ovf/zero directly. No output logic follows the register apart from what the Optional Feature allows.
- Handshake:
  - Accept occurs when in_valid && in_ready on a rising edge.
  - Produce occurs when out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall. This is a global stall: all stages hold when stall=1.
  - When not stalled, every stage advances each cycle and bubbles flow through.
  - Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES-1, with no stall.
  - Throughput: one beat per cycle.
  - Outputs are held stable while out_valid && !out_ready.
  - With STAGES=1: single registered adder, result valid after the accepting edge.
- Boundary conditions:
  - A simultaneous produce and accept in the same cycle is legal and is the steady-state case.
  - When in_valid=0, a bubble enters. A bubble's data is don't-care, but out_valid=0.
  - Inputs are only sampled on accept. Changing them while in_ready=0 has no effect.
  - Beat order is strictly preserved, and no beat is ever dropped or duplicated.

Optional Feature:
- Macro: PIPELINED_ADDSUB_SATURATE_EN.
- Defined:
  - In the final stage, if ovf=1, sum clamps to 0x7F..F when the true result is positive (A sign 0), and to 0x80..0 when it is negative (A sign 1).
  - ovf still reports 1.
  - zero is computed on the clamped value.
  - cout is unchanged.
  - Latency is unchanged.
- Not defined: wrap-around result, with no clamping logic synthesised.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- Reset: hold reset 3 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0, ovf=0, zero=0 throughout. in_ready=1 after release.
- Add with carry: 0x1234 + 0x0FFF, cin=0, op=0, accepted at edge 0 -> after edge 3: sum=0x2233, cout=0, ovf=0, zero=0.
- Full ripple: 0xFFFF + 0x0000, cin=1 -> sum=0x0000, cout=1, zero=1, ovf=0. The carry must cross all 4 chunk stages.
- Subtract with borrow: 0x0005 - 0x0007, op=1, cin=0 -> sum=0xFFFE, cout=0. Repeat with cin=1 -> sum=0xFFFD.
- Overflow: 0x7FFF + 0x0001 -> sum=0x8000, ovf=1. With PIPELINED_ADDSUB_SATURATE_EN -> sum=0x7FFF, ovf=1. 0x8000 - 0x0001 -> 0x7FFF, ovf=1 (saturated: 0x8000).
- Backpressure stream: 8 back-to-back beats (A=i, B=i*0x1111), out_ready=0 for cycles 5-7 -> in_ready=0 in exactly those cycles. All 8 results emerge in order, with outputs held stable during the stall. Assert reset mid-stream -> everything is flushed, and out_valid=0 on the cycle reset is asserted.

Source files
------------

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: valid/ready flow-controlled adder/subtractor.
// The WIDTH-bit operation is resolved CW = WIDTH/STAGES bits per stage, and
// the carry is registered between stages. One global stall holds every stage
// while the output beat is presented but not taken.
// Optional build macro: PIPELINED_ADDSUB_SATURATE_EN clamps overflowing
// results to the most positive or most negative value in the final stage.
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] augend,
    input  logic [WIDTH-1:0] addend,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    // Per-stage state: valid, carry out of the latest chunk, partial result,
    // and the operands (B already conditioned for subtract).
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic [WIDTH-1:0]  r_d [STAGES];
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic              stall;
    logic [WIDTH-1:0]  src_a, src_b, src_r;
    logic              src_c, src_v, cmsb;
    logic [CW:0]       chunk;
    int unsigned       p;

    // Global stall: the presented result has not been taken.
    always_comb begin
        stall    = v_q[LAST] && !out_ready;
        in_ready = !stall;
    end

    // Next state of every stage: stage s adds chunk s of its source plus the
    // incoming carry; stage 0 sources the ports, others the previous stage.
    always_comb begin
        v_d    = '0;
        c_d    = '0;
        ovf_d  = 1'b0;
        zero_d = 1'b0;
        src_a  = '0;
        src_b  = '0;
        src_r  = '0;
        src_c  = 1'b0;
        src_v  = 1'b0;
        cmsb   = 1'b0;
        chunk  = '0;
        p      = 0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            a_d[s] = '0;
            b_d[s] = '0;
            r_d[s] = '0;
        end
        for (int unsigned s = 0; s < STAGES; s++) begin
            p = (s == 0) ? 0 : s - 1;
            if (s == 0) begin
                src_a = augend;
                src_b = op ? ~addend : addend;
                src_c = op ? ~cin : cin;
                src_r = '0;
                src_v = in_valid;
            end else begin
                src_a = a_q[p];
                src_b = b_q[p];
                src_c = c_q[p];
                src_r = r_q[p];
                src_v = v_q[p];
            end
            chunk = {1'b0, src_a[s*CW +: CW]} + {1'b0, src_b[s*CW +: CW]}
                  + {{CW{1'b0}}, src_c};
            a_d[s] = src_a;
            b_d[s] = src_b;
            r_d[s] = src_r;
            r_d[s][s*CW +: CW] = chunk[CW-1:0];
            c_d[s] = chunk[CW];
            v_d[s] = src_v;
        end
        // After the loop src_a/src_b hold the final stage's operands; the
        // carry into the MSB is recovered from the MSB sum bit.
        cmsb  = r_d[LAST][WIDTH-1] ^ src_a[WIDTH-1] ^ src_b[WIDTH-1];
        ovf_d = cmsb ^ c_d[LAST];
`ifdef PIPELINED_ADDSUB_SATURATE_EN
        if (ovf_d) begin
            r_d[LAST] = src_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        zero_d = (r_d[LAST] == '0);
    end

    // Stage registers: cleared asynchronously, all advance together unless stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                a_q[s] <= '0;
                b_q[s] <= '0;
                r_q[s] <= '0;
            end
        end else if (!stall) begin
            v_q    <= v_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            for (int unsigned s = 0; s < STAGES; s++) begin
                a_q[s] <= a_d[s];
                b_q[s] <= b_d[s];
                r_q[s] <= r_d[s];
            end
        end
    end

    // Outputs come straight from the final stage register.
    always_comb begin
        out_valid = v_q[LAST];
        sum       = r_q[LAST];
        cout      = c_q[LAST];
        ovf       = ovf_q;
        zero      = zero_q;
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (WIDTH=16, STAGES=4).
// Honours PIPELINED_ADDSUB_SATURATE_EN for the overflow expectations.
module tb_pipelined_addsub;

    localparam int unsigned W = 16;
    localparam int unsigned S = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] augend;
    logic [W-1:0] addend;
    logic         cin;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .augend   (augend),
        .addend   (addend),
        .cin      (cin),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One beat followed by bubbles; checks latency, result and flags.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic o, input logic [W-1:0] es,
                          input logic ec, input logic eo, input logic ez);
        in_valid = 1'b1;
        augend   = a;
        addend   = b;
        cin      = ci;
        op       = o;
        @(posedge clk); #1;
        in_valid = 1'b0;
        augend   = a ^ 16'hA5A5;
        addend   = b ^ 16'h5A5A;
        cin      = ~ci;
        op       = ~o;
        repeat (S - 2) begin
            @(posedge clk); #1;
        end
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_flags"}, 32'({cout, ovf, zero}), 32'({ec, eo, ez}));
        @(posedge clk); #1;
        chk({tag, "_nodup"}, 32'(out_valid), 32'd0);
    endtask

    logic [W-1:0] a_tbl [8];
    logic [W-1:0] b_tbl [8];
    logic [W-1:0] e_tbl [8];

    initial begin
        int beat;
        int got;
        logic acc;

        a_tbl = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
        b_tbl = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
        e_tbl = '{16'h0000, 16'h1112, 16'h2224, 16'h3336, 16'h4448, 16'h555A, 16'h666C, 16'h777E};

        // Reset held 3 cycles with a beat offered.
        reset     = 1'b1;
        in_valid  = 1'b1;
        augend    = 16'hFFFF;
        addend    = 16'h0001;
        cin       = 1'b1;
        op        = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("reset_out", 32'({out_valid, sum, cout, ovf, zero}), 32'd0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(in_ready), 32'd1);
        chk("idle_after_reset", 32'(out_valid), 32'd0);

        run_op("add_carry", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        run_op("full_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("sub_borrow0", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_borrow1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0);
        run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
`ifdef PIPELINED_ADDSUB_SATURATE_EN
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
        run_op("ovf_negadd", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op("ovf_negadd", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
`endif

        // Back-to-back stream with out_ready low in cycles 5..7.
        beat = 0;
        got  = 0;
        cin  = 1'b0;
        op   = 1'b0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            out_ready = !(c >= 5 && c <= 7);
            if (beat < 8) begin
                in_valid = 1'b1;
                augend   = a_tbl[beat];
                addend   = b_tbl[beat];
            end else begin
                in_valid = 1'b0;
                augend   = 16'hDEAD;
                addend   = 16'hBEEF;
            end
            @(negedge clk);
            if (c <= 10) begin
                chk($sformatf("stream_in_ready_c%0d", c), 32'(in_ready),
                    (c >= 5 && c <= 7) ? 32'd0 : 32'd1);
            end
            if (c >= 5 && c <= 7) begin
                chk($sformatf("stall_valid_c%0d", c), 32'(out_valid), 32'd1);
                chk($sformatf("stall_hold_c%0d", c), 32'(sum), 32'(e_tbl[got]));
            end else if (out_valid) begin
                chk($sformatf("stream_sum_%0d", got), 32'(sum), 32'(e_tbl[got]));
                got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) beat++;
        end
        chk("stream_count", 32'(got), 32'd8);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Reset asserted mid-stream flushes every stage.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            augend   = a_tbl[i];
            addend   = b_tbl[i];
            @(posedge clk); #1;
        end
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_out", 32'({out_valid, sum, cout, ovf, zero}), 32'd0);
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("flushed_%0d", i), 32'(out_valid), 32'd0);
        end

        run_op("post_reset_add", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
